// File: rtl/display_mode_sequencer_pkg.sv
// display_mode_sequencer_pkg: shared state codes, segment masks and switch patterns
//   STATE_WIDTH / state_t      : state code carried on o_State
//   SEGMENT_A..SEGMENT_G       : one-hot segment masks (bit0 = A .. bit6 = G)
//   COMBO/HOLD/RELEASE_PATTERN : switch patterns that drive mode changes
package display_mode_sequencer_pkg;
    localparam int STATE_WIDTH = 3;
    typedef enum logic [STATE_WIDTH-1:0] {
        STATE_INIT       = 3'd0,
        STATE_SWITCH     = 3'd1,
        STATE_BIT        = 3'd2,
        STATE_RESET_WAIT = 3'd3,
        STATE_AUTO       = 3'd4
    } state_t;
    localparam logic [6:0] SEGMENT_A = 7'b0000001;
    localparam logic [6:0] SEGMENT_B = 7'b0000010;
    localparam logic [6:0] SEGMENT_C = 7'b0000100;
    localparam logic [6:0] SEGMENT_D = 7'b0001000;
    localparam logic [6:0] SEGMENT_E = 7'b0010000;
    localparam logic [6:0] SEGMENT_F = 7'b0100000;
    localparam logic [6:0] SEGMENT_G = 7'b1000000;
    localparam logic [3:0] COMBO_PATTERN   = 4'b1001;
    localparam logic [3:0] HOLD_PATTERN    = 4'b1111;
    localparam logic [3:0] RELEASE_PATTERN = 4'b0000;
    // The chase only walks the six outer segments; G is never lit.
    function automatic logic [6:0] next_chase(input logic [6:0] seg);
        return seg == SEGMENT_F ? SEGMENT_A : seg << 1;
    endfunction
    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/display_mode_sequencer_tick_divider.sv
// Tick_Divider: one-cycle step pulse every CLKS_PER_STEP clocks
//   i_Clk   : system clock
//   i_Rst_L : asynchronous active-low reset
//   i_Clear : holds the divider at count 0 and suppresses the pulse
//   o_Tick  : high for the last clock of each step
module Tick_Divider
    import display_mode_sequencer_pkg::*;
#(
    parameter int CLKS_PER_STEP = 3125000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clear,
    output logic o_Tick
);
    localparam int W = cnt_width(CLKS_PER_STEP);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_STEP - 1);
    logic [W-1:0] count;
    assign o_Tick = !i_Clear && count == LAST;
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) count <= '0;
        else count <= (i_Clear || o_Tick) ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/display_mode_sequencer.sv
// display_mode_sequencer: power-up chase, mode cycling and hold-to-reset control
//   i_Clk      : system clock
//   i_Rst_L    : asynchronous active-low reset
//   i_Switches : debounced switch levels, bit0 = switch 1
//   o_State    : registered state code
//   o_Segments : one-hot chase segments during INIT, zero otherwise
//   o_Auto_Run : high only while in AUTO
module display_mode_sequencer
    import display_mode_sequencer_pkg::*;
#(
    parameter int CLKS_PER_STEP = 3125000,
    parameter int INIT_STEPS    = 12,
    parameter int HOLD_CLKS     = 50000000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [3:0]             i_Switches,
    output logic [STATE_WIDTH-1:0] o_State,
    output logic [6:0]             o_Segments,
    output logic                   o_Auto_Run
);
    localparam int SW = cnt_width(INIT_STEPS);
    localparam int HW = cnt_width(HOLD_CLKS);
    localparam logic [SW-1:0] LAST_STEP = SW'(INIT_STEPS - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD_CLKS - 1);
    state_t state, state_next;
    logic [SW-1:0] step;
    logic [HW-1:0] hold;
    logic [3:0] prev_switches;
    logic tick, combo, holding, hold_done, stay_init;
    // The divider idles at zero outside INIT, so every entry to INIT starts a full step.
    Tick_Divider #(.CLKS_PER_STEP(CLKS_PER_STEP)) u_tick (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clear (state != STATE_INIT),
        .o_Tick  (tick)
    );
    always_comb begin
        holding   = i_Switches == HOLD_PATTERN && state != STATE_RESET_WAIT;
        hold_done = holding && hold == LAST_HOLD;
        combo     = i_Switches == COMBO_PATTERN && prev_switches != COMBO_PATTERN;
        state_next = STATE_INIT;
        case (state)
            STATE_INIT:       state_next = tick && step == LAST_STEP ? STATE_AUTO : STATE_INIT;
            STATE_AUTO:       state_next = combo ? STATE_SWITCH : STATE_AUTO;
            STATE_SWITCH:     state_next = combo ? STATE_BIT : STATE_SWITCH;
            STATE_BIT:        state_next = combo ? STATE_AUTO : STATE_BIT;
            STATE_RESET_WAIT: state_next = i_Switches == RELEASE_PATTERN ? STATE_INIT : STATE_RESET_WAIT;
            default:          state_next = STATE_INIT;
        endcase
        // A completed hold overrides every other transition.
        if (hold_done) state_next = STATE_RESET_WAIT;
        stay_init = state == STATE_INIT && state_next == STATE_INIT;
    end
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= STATE_INIT;
            step          <= '0;
            hold          <= '0;
            prev_switches <= '0;
            o_Segments    <= SEGMENT_A;
            o_Auto_Run    <= 1'b0;
        end else begin
            state         <= state_next;
            prev_switches <= i_Switches;
            o_Auto_Run    <= state_next == STATE_AUTO;
            hold          <= holding && !hold_done ? hold + 1'b1 : '0;
            step          <= !stay_init ? '0 : tick ? step + 1'b1 : step;
            o_Segments    <= state_next != STATE_INIT ? '0 :
                             !stay_init ? SEGMENT_A :
                             tick ? next_chase(o_Segments) : o_Segments;
        end
    end
    assign o_State = state;
endmodule

// File: doc/display_mode_sequencer.md
Name: display_mode_sequencer

Overview:
Top-level mode controller for the seven-segment counter design. It sequences the display datapath through a power-up segment-chase animation, then the three counting modes (auto, switch, bit), and a reset-wait state entered by a long four-switch hold. It drives the state code that selects the nibble source and segment override, the one-hot animation segments, and the auto-counter run enable.

Parameters:
CLKS_PER_STEP, 3125000, clocks per animation step (125 ms at 25 MHz); must be >= 2
INIT_STEPS, 12, animation steps before leaving INIT (two laps of six outer segments)
HOLD_CLKS, 50000000, clocks that all four switches must be held to enter RESET_WAIT (2 s)

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Switches  in  4  debounced switch levels; bit0 = switch 1, bit3 = switch 4
o_State  out  3  state code: INIT=3'd0, SWITCH=3'd1, BIT=3'd2, RESET_WAIT=3'd3, AUTO=3'd4
o_Segments  out  7  active-high animation segments; bit0 = A through bit6 = G
o_Auto_Run  out  1  high only in AUTO (auto counter held in reset otherwise)

Behaviour:
- Reset (i_Rst_L low, asynchronous): state INIT, step timer 0, step index 0, hold counter 0, previous-switch register 4'b0000. Outputs: o_State=0, o_Segments=7'b0000001, o_Auto_Run=0.
- All outputs are registered. o_State changes one clock after the qualifying edge. o_Auto_Run is decoded from the state register, so it changes in the same cycle as o_State.
- INIT:
  - The step timer counts 0..CLKS_PER_STEP-1 and then wraps, advancing the step index.
  - o_Segments is one-hot at bit (index mod 6), giving the chase A,B,C,D,E,F,A,...
  - On the wrap that completes step INIT_STEPS-1, the state goes to AUTO and o_Segments goes to 0. INIT therefore lasts exactly INIT_STEPS*CLKS_PER_STEP cycles.
  - Mode-change combos are ignored in INIT.
- Mode change:
  - The combo is a rising edge of the exact pattern 4'b1001: current i_Switches==4'b1001 and previous!=4'b1001.
  - Each combo advances AUTO->SWITCH->BIT->AUTO.
  - Holding the pattern does not repeat the advance. Release and re-press is required.
- Hold-to-reset:
  - The hold counter increments every cycle that i_Switches==4'b1111, in all states except RESET_WAIT.
  - It clears to 0 on any other pattern.
  - When it reaches HOLD_CLKS-1 while the pattern is still 4'b1111, the next state is RESET_WAIT. The counter saturates and is cleared on entry.
  - Transition occurs exactly HOLD_CLKS cycles after the first 4'b1111 sample.
- RESET_WAIT:
  - o_Segments=0 and o_Auto_Run=0.
  - When i_Switches==4'b0000 is sampled, the state goes to INIT and the step timer and index clear, restarting the animation from segment A.
- Priority when events coincide: hold-complete beats combo, and combo beats the INIT timeout. The INIT timeout and the combo cannot conflict, since combos are ignored in INIT.
- Counter widths: $clog2 of the respective parameter. No wrap beyond the terminal count.
- Illegal state codes (5..7) recover to INIT on the next clock.
- Reset asserted mid-operation returns to the reset values immediately, regardless of state or counters.

Decomposition:
- Shared header (extends the existing state/segment include):
  - STATE_WIDTH=3
  - STATE_INIT/SWITCH/BIT/RESET_WAIT/AUTO codes
  - SEGMENT_A..G one-hot masks
- Sub-module Tick_Divider (parameter CLKS_PER_STEP; ports i_Clk, i_Rst_L, i_Clear, o_Tick). It generates the one-cycle animation step pulse and is reusable by the auto counter.
- Hold counter and combo edge detector stay inline.

Test Plan (CLKS_PER_STEP=4, INIT_STEPS=12, HOLD_CLKS=10):
- Power-up:
  - Stimulus: release i_Rst_L, switches 0.
  - Required: o_Segments walks 01,02,04,08,10,20,01,... changing every 4 clocks. o_State=0 for 48 clocks, then 4 with o_Auto_Run=1 and o_Segments=0.
- Mode cycling:
  - Stimulus: in AUTO, apply 1001 for 3 clocks then 0000, three times.
  - Required: o_State 4->1->2->4, exactly one advance per press.
- Combo ignored in INIT:
  - Stimulus: apply 1001 at cycle 10 after reset.
  - Required: o_State stays 0 and reaches 4 at cycle 48.
- Hold-to-reset:
  - Stimulus: in BIT, apply 1111 for 9 clocks, then 0001, then 1111 for 10 clocks.
  - Required: no transition on the first hold. o_State=3 exactly 10 cycles after the second hold starts.
  - Then apply 0000: o_State=0 next cycle, o_Segments=01, animation restarts.
- RESET_WAIT release:
  - Stimulus: in RESET_WAIT, drop switches to 1000 and then 0110.
  - Required: o_State stays 3 until 0000 is seen.
- Async reset mid-run:
  - Stimulus: pull i_Rst_L low between clock edges while in SWITCH with hold counter=5.
  - Required: o_State=0 and o_Segments=01 before the next edge. After release, the hold count restarts at 0.
